// File: rtl/edge_pkg.sv
// Shared constants and state encoding for the edge-map streamer: a 128x128
// binary map filled from a 4x4 tile array and drained as packed bytes.
package edge_pkg;

  localparam int DIM           = 128;
  localparam int GRID          = 4;
  localparam int T             = DIM / GRID;
  localparam int BYTES_PER_ROW = DIM / 8;
  localparam int FRAME_BYTES   = DIM * DIM / 8;

  localparam int T_W    = $clog2(T);
  localparam int BEAT_W = 2 * T_W;
  localparam int BYTE_W = $clog2(FRAME_BYTES);
  localparam int ROW_W  = $clog2(DIM);
  localparam int COLB_W = $clog2(BYTES_PER_ROW);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(T * T - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    PREFETCH = 2'd1,
    DRAIN    = 2'd2
  } state_e;

endpackage

// File: rtl/edge_bitmap_ram.sv
// DIM x DIM bit map: GRID*GRID scattered single-bit writes per beat and one
// registered byte read per cycle (MSB = leftmost pixel).
module edge_bitmap_ram
  import edge_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [BEAT_W-1:0]      wr_beat,
  input  logic [GRID*GRID-1:0]   wr_bits,
  input  logic                   rd_en,
  input  logic [BYTE_W-1:0]      rd_addr,
  output logic [7:0]             rd_data
);

  logic [DIM-1:0]   mem_q [DIM];
  logic [ROW_W-1:0] wr_row [GRID];
  logic [ROW_W-1:0] wr_col [GRID];
  logic [T_W-1:0]   beat_i;
  logic [T_W-1:0]   beat_j;
  logic [ROW_W-1:0] rd_row;
  logic [ROW_W-1:0] rd_c0;
  logic [DIM-1:0]   rd_line;
  logic [7:0]       rd_byte;
  logic [7:0]       rd_q;

  assign beat_i = wr_beat[BEAT_W-1:T_W];
  assign beat_j = wr_beat[T_W-1:0];

  // Beat (i, j) lands at the same offset inside every tile.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int a = 0; a < GRID; a++) begin
      wr_row[a] = ROW_W'(a * T) + ROW_W'(beat_i);
      wr_col[a] = ROW_W'(a * T) + ROW_W'(beat_j);
    end
  end

  // NOTE: the map array has no reset; every bit is rewritten each frame, so clearing it is wasted logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int a = 0; a < GRID; a++) begin
        for (int b = 0; b < GRID; b++) begin
          mem_q[wr_row[a]][wr_col[b]] <= wr_bits[a * GRID + b];
        end
      end
    end
  end

  assign rd_row = rd_addr[BYTE_W-1:COLB_W];
  assign rd_c0  = {rd_addr[COLB_W-1:0], 3'b000};

  always_comb begin
    rd_line = mem_q[rd_row];
    rd_byte = '0;
    for (int x = 0; x < 8; x++) begin
      rd_byte[7-x] = rd_line[rd_c0 + ROW_W'(x)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= rd_byte;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/edge_map_streamer.sv
// Collects 1024 beats of tile edge bits into the map, then streams the map
// row-major as bytes over valid/ready; one frame in flight at a time.
module edge_map_streamer
  import edge_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [GRID*GRID-1:0] in_bits,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frame_sent
);

  state_e              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [BYTE_W-1:0]   byte_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                frame_sent_q;

  logic                beat_fire;
  logic                out_fire;
  logic [BYTE_W-1:0]   byte_d;
  logic                rd_en;
  logic [BYTE_W-1:0]   rd_addr;

  assign beat_fire = in_valid && in_ready_q;
  assign out_fire  = out_valid_q && out_ready;
  assign byte_d    = byte_q + 1'b1;

  // The read register is only advanced on a transfer, which keeps out_data stable under stall.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = byte_d;
    if (state_q == PREFETCH) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if (state_q == DRAIN && out_fire && byte_q != LAST_BYTE) begin
      rd_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      beat_q       <= '0;
      byte_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      frame_sent_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (beat_fire) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q    <= PREFETCH;
              in_ready_q <= 1'b0;
            end
          end
        end
        PREFETCH: begin
          state_q     <= DRAIN;
          byte_q      <= '0;
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
        end
        DRAIN: begin
          if (out_fire) begin
            if (byte_q == LAST_BYTE) begin
              state_q      <= FILL;
              byte_q       <= '0;
              in_ready_q   <= 1'b1;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              frame_sent_q <= 1'b1;
            end else begin
              byte_q     <= byte_d;
              out_last_q <= (byte_d == LAST_BYTE);
            end
          end
        end
        default: begin
          state_q    <= FILL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  edge_bitmap_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (beat_fire),
    .wr_beat (beat_q),
    .wr_bits (in_bits),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_sent = frame_sent_q;

endmodule

// File: tb/tb_edge_map_streamer.sv
// Frame-level bench for edge_map_streamer: table of frames with spot bytes,
// full-frame model compare, plus a reset-mid-drain sequence.
module tb_edge_map_streamer;

  localparam int M_ZERO    = 0;
  localparam int M_ONES    = 1;
  localparam int M_SINGLE  = 2;
  localparam int M_CHECKER = 3;
  localparam int NBYTES    = 2048;
  localparam int NBEATS    = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_bits = '0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        frame_sent;

  int n_checks = 0;
  int n_err    = 0;
  int fs_count = 0;

  logic [7:0] got [NBYTES];

  typedef struct {
    int         mode;
    int         kbit;
    int         nbeat;
    bit         bp;
    bit         ign;
    int         byte_idx;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  edge_map_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bits    (in_bits),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_sent (frame_sent)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_sent === 1'b1) fs_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] beat_bits(input int mode, input int kbit, input int nbeat, input int n);
    logic [15:0] one;
    one = 16'h0001;
    case (mode)
      M_ONES:    return 16'hFFFF;
      M_SINGLE:  return (n == nbeat) ? (one << kbit) : 16'h0000;
      M_CHECKER: return (((n / 32) + (n % 32)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      default:   return 16'h0000;
    endcase
  endfunction

  function automatic logic exp_pix(input int mode, input int kbit, input int nbeat, input int r, input int c);
    int i, j, k, n;
    i = r % 32;
    j = c % 32;
    k = (r / 32) * 4 + (c / 32);
    n = i * 32 + j;
    case (mode)
      M_ONES:    return 1'b1;
      M_SINGLE:  return (k == kbit && n == nbeat);
      M_CHECKER: return ((i + j) % 2 == 1);
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int mode, input int kbit, input int nbeat, input int m);
    logic [7:0] b;
    int r, c0;
    r  = m / 16;
    c0 = 8 * (m % 16);
    b  = '0;
    for (int x = 0; x < 8; x++) b[7-x] = exp_pix(mode, kbit, nbeat, r, c0 + x);
    return b;
  endfunction

  // Called at a negedge where in_ready should be high; returns at the negedge after the last beat.
  task automatic send_frame(input int mode, input int kbit, input int nbeat);
    int fill_err = 0;
    int lat;
    for (int n = 0; n < NBEATS; n++) begin
      in_valid = 1'b1;
      in_bits  = beat_bits(mode, kbit, nbeat, n);
      if (in_ready !== 1'b1) fill_err++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_bits  = '0;
    check("fill_in_ready_low", 32'(fill_err), 32'd0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("valid_latency", 32'(lat), 32'd2);
  endtask

  task automatic drain_frame(input bit bp, input bit ign, output int cnt);
    int   cyc = 0;
    int   last_err = 0, stall_err = 0, ir_err = 0;
    bit   held_v = 0;
    logic [7:0] held_d = '0;
    logic held_l = 1'b0;
    logic rdy;
    cnt = 0;
    while (cnt < NBYTES && cyc < 8000) begin
      if (held_v && (out_data !== held_d || out_last !== held_l || out_valid !== 1'b1)) stall_err++;
      if (in_ready !== 1'b0) ir_err++;
      rdy       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      in_valid  = ign && (cnt < NBYTES - 1);
      in_bits   = 16'hFFFF;
      if (out_valid === 1'b1 && rdy) begin
        got[cnt] = out_data;
        if (out_last !== (cnt == NBYTES - 1)) last_err++;
        cnt++;
        held_v = 0;
      end else if (out_valid === 1'b1) begin
        held_v = 1;
        held_d = out_data;
        held_l = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_bits   = '0;
    check("drain_transfers", 32'(cnt), 32'(NBYTES));
    check("out_last_placement", 32'(last_err), 32'd0);
    check("stall_stable", 32'(stall_err), 32'd0);
    check("drain_in_ready_low", 32'(ir_err), 32'd0);
    check("frame_sent_pulse", 32'(frame_sent), 32'd1);
    check("post_frame_valid", 32'(out_valid), 32'd0);
    check("post_frame_last", 32'(out_last), 32'd0);
    check("post_frame_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    int cnt;
    int bad = 0;
    send_frame(v.mode, v.kbit, v.nbeat);
    drain_frame(v.bp, v.ign, cnt);
    for (int m = 0; m < cnt; m++) begin
      if (got[m] !== exp_byte(v.mode, v.kbit, v.nbeat, m)) bad++;
    end
    check("frame_model_bytes", 32'(bad), 32'd0);
    if (cnt > v.byte_idx) check("spot_byte", 32'(got[v.byte_idx]), 32'(v.exp));
    else check("spot_byte_missing", 32'(cnt), 32'(v.byte_idx + 1));
  endtask

  initial begin
    vecs[0]  = '{M_ONES,    0,   0,   1'b0, 1'b0, 2047, 8'hFF};
    vecs[1]  = '{M_SINGLE,  5,   103, 1'b0, 1'b0, 564,  8'h01};
    vecs[2]  = '{M_SINGLE,  0,   0,   1'b0, 1'b0, 0,    8'h80};
    vecs[3]  = '{M_SINGLE,  1,   0,   1'b0, 1'b0, 4,    8'h80};
    vecs[4]  = '{M_SINGLE,  2,   0,   1'b0, 1'b0, 8,    8'h80};
    vecs[5]  = '{M_SINGLE,  3,   0,   1'b0, 1'b0, 12,   8'h80};
    vecs[6]  = '{M_SINGLE,  4,   0,   1'b0, 1'b0, 512,  8'h80};
    vecs[7]  = '{M_SINGLE,  8,   0,   1'b0, 1'b0, 1024, 8'h80};
    vecs[8]  = '{M_SINGLE,  12,  0,   1'b0, 1'b0, 1536, 8'h80};
    vecs[9]  = '{M_SINGLE,  15,  0,   1'b1, 1'b0, 1548, 8'h80};
    vecs[10] = '{M_CHECKER, 0,   0,   1'b1, 1'b0, 16,   8'hAA};
    vecs[11] = '{M_ZERO,    0,   0,   1'b0, 1'b1, 0,    8'h00};
    vecs[12] = '{M_SINGLE,  5,   103, 1'b0, 1'b0, 564,  8'h01};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_frame_sent", 32'(frame_sent), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 13; v++) run_frame(vecs[v]);

    // Reset in the middle of a drain: partial frame dropped, no frame_sent.
    send_frame(M_ONES, 0, 0);
    out_ready = 1'b1;
    repeat (1000) @(negedge clk);
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_frame_sent", 32'(frame_sent), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_frame('{M_ONES, 0, 0, 1'b0, 1'b0, 1000, 8'hFF});

    repeat (3) @(negedge clk);
    check("frame_sent_total", 32'(fs_count), 32'd14);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_map_streamer.md
Name: edge_map_streamer

Overview:
- Downstream stage of the 16-tile edge-detection array.
- Each cycle it accepts the 16 edge bits the array produces in its 32x32 scan order and assembles them into a 128x128 binary edge map.
- Once the frame is complete, it streams the map out row-major as packed bytes over a valid/ready interface (for a UART/host bridge).
- Alternates between a fill phase and a drain phase; one frame in flight at a time.

Parameters:
- DIM, 128, image side in pixels; power of two, multiple of 8*GRID.
- GRID, 4, tiles per side; tile side T = DIM/GRID = 32.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  edge beat present
- in_bits  in  GRID*GRID  edge bits of one beat; bit k belongs to tile row a=k/GRID, tile col b=k%GRID
- in_ready  out  1  high only in FILL
- out_data  out  8  packed edge byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts byte
- out_last  out  1  final byte of frame (with out_valid)
- frame_sent  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset values:
  - in_ready=1 (state FILL).
  - out_valid=0, out_last=0, out_data=0, frame_sent=0.
  - Beat counter and byte counter are 0.
  - Map storage is not cleared; every bit is rewritten each frame.
- States: FILL -> PREFETCH -> DRAIN -> FILL.
- FILL:
  - A beat transfers when in_valid && in_ready.
  - Beat counter n (0..T*T-1) gives i=n/T, j=n%T.
  - Bit k is written to map[i+T*a][j+T*b].
  - After the beat with n=T*T-1 (1024th), go to PREFETCH; counter wraps to 0.
  - in_valid while in_ready=0 is ignored; no error flag.
- PREFETCH:
  - One cycle; loads byte 0 into out_data.
  - Next cycle enters DRAIN with out_valid=1.
  - Latency: last input beat accepted in cycle N -> out_valid first high in cycle N+2.
- DRAIN, byte index m (0..DIM*DIM/8-1 = 2047):
  - Byte m covers row r=m/(DIM/8), columns c0=8*(m%(DIM/8)) .. c0+7.
  - out_data[7] = map[r][c0], ..., out_data[0] = map[r][c0+7] (MSB = leftmost pixel).
  - A transfer occurs when out_valid && out_ready.
  - On a transfer, byte m+1 is presented the next cycle, giving a zero-bubble stream at full throughput.
  - While out_ready=0, out_data and out_last are held stable.
  - out_last is high exactly while m=2047.
- End of frame:
  - When byte 2047 transfers, go to FILL the next cycle: out_valid=0, out_last=0, in_ready=1, frame_sent=1 for one cycle.
  - The first beat of the next frame may be accepted in that same cycle.
- Reset mid-operation (any state): next cycle is the reset state. A partial frame is discarded and no frame_sent is produced.
- Widths:
  - Beat counter: 2*log2(T) bits.
  - Byte counter: log2(DIM*DIM/8) bits.
  - All counter arithmetic is unsigned, modulo its width.

Decomposition:
- Shared package edge_pkg:
  - Constants DIM, GRID, T, BYTES_PER_ROW=DIM/8, FRAME_BYTES=DIM*DIM/8.
  - State enum {FILL, PREFETCH, DRAIN}.
- Sub-module edge_bitmap_ram: DIM rows x DIM bits.
  - Write side: GRID*GRID independent single-bit writes per cycle at (i+T*a, j+T*b).
  - Read side: one synchronous 8-bit byte read per cycle at (r, c0).
- Top edge_map_streamer holds the FSM, both counters and the output register.

Test Plan:
- All-ones frame: 1024 beats of in_bits=16'hFFFF, out_ready=1 -> 2048 bytes of 8'hFF. out_valid first high 2 cycles after the last beat. out_last only on byte 2047, frame_sent one cycle after it.
- Single-bit placement: bit 5 high only on beat n=103 (i=3, j=7), all other bits 0 -> pixel (35,39) -> byte 564=8'h01. All other bytes are 8'h00.
- Tile ordering: bit k high only on beat n=0, for each k -> byte index (32*(k/4))*16 + 4*(k%4) = 8'h80.
- Backpressure: toggle out_ready randomly at 50% over a full drain of the all-ones/checkerboard map.
  - out_data is stable while stalled.
  - No byte is lost or duplicated; exactly 2048 transfers.
  - in_ready=0 throughout.
- Ignored input: drive in_valid=1 with 16'hFFFF during DRAIN of an all-zero frame -> all output bytes are 8'h00. The next frame's beat counter starts at 0.
- Reset mid-drain: assert reset at byte 1000 -> next cycle in_ready=1, out_valid=0, frame_sent never pulses. A following all-ones frame streams 2048 bytes of 8'hFF.
